// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-control peripheral: register map,
// controller states and the verdict codes software and the watchdog write.
package sim_ctrl_pkg;

    localparam logic [7:0] SC_TESTNUM  = 8'h00;
    localparam logic [7:0] SC_FINISH   = 8'h04;
    localparam logic [7:0] SC_CYCLE_LO = 8'h08;
    localparam logic [7:0] SC_CYCLE_HI = 8'h0C;
    localparam logic [7:0] SC_WDOG     = 8'h10;
    localparam logic [7:0] SC_STATUS   = 8'h14;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FINISHING = 2'd1,
        DONE      = 2'd2
    } sc_state_e;

    localparam logic [31:0] PASS_CODE    = 32'd1;
    localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001;

endpackage

// File: rtl/sim_ctrl_if.sv
// Data-bus port of the simulation-control peripheral. The CPU side is the
// master; the peripheral is the slave and answers reads one cycle later.
interface sim_ctrl_if #(
    parameter int AW = 8
);
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          rvalid_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, rvalid_o
    );
endinterface

// File: rtl/sim_ctrl_wdog.sv
// Free-running 64-bit cycle counter plus the watchdog comparator. The hit
// output is high for the cycle in which the low counter word equals a
// nonzero limit while the controller has armed the watchdog.
module sim_ctrl_wdog (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_en,
    input  logic        arm,
    input  logic [31:0] limit,
    output logic [63:0] cycle,
    output logic        hit
);

    // Count every enabled cycle, wrapping naturally at 2^64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle <= '0;
        end else if (count_en) begin
            cycle <= cycle + 64'd1;
        end
    end

    assign hit = arm && (limit != 32'd0) && (cycle[31:0] == limit);

endmodule

// File: rtl/sim_ctrl.sv
// Simulation-control peripheral: test software writes its test number and a
// final verdict; the block drains in-flight stores, then latches done/pass
// for the testbench. A watchdog forces a failing finish if software hangs.
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int          AW           = 8,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] WDOG_RESET   = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    sim_ctrl_if.slave   bus,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] testnum_o,
    output logic        timeout_o
);

    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);

    sc_state_e     state;
    logic [31:0]   testnum_q;
    logic [31:0]   code_q;
    logic [31:0]   wdog_q;
    logic [DW-1:0] drain_q;
    logic          verdict_q;

    logic [63:0]   cycle;
    logic          hit;
    logic          count_en;
    logic          arm;

    logic [AW-1:0] word_addr;
    logic          wr, rd;
    logic          sel_testnum, sel_finish, sel_cycle_lo, sel_cycle_hi;
    logic          sel_wdog, sel_status;
    logic          fin_wr;
    logic [31:0]   status;
    logic [31:0]   read_data;

    // The address LSBs are masked off so any byte address hits its word.
    assign word_addr    = bus.addr_i & ~AW'(3);
    assign wr           = bus.req_i & bus.we_i;
    assign rd           = bus.req_i & ~bus.we_i;
    assign sel_testnum  = (word_addr == AW'(SC_TESTNUM));
    assign sel_finish   = (word_addr == AW'(SC_FINISH));
    assign sel_cycle_lo = (word_addr == AW'(SC_CYCLE_LO));
    assign sel_cycle_hi = (word_addr == AW'(SC_CYCLE_HI));
    assign sel_wdog     = (word_addr == AW'(SC_WDOG));
    assign sel_status   = (word_addr == AW'(SC_STATUS));

    // Only the first nonzero FINISH write while running carries a verdict.
    assign fin_wr = wr && sel_finish && (bus.wdata_i != 32'd0) && (state == RUN);

    // The counter stops on the edge that enters DONE, so its frozen value is
    // the cycle in which completion was decided.
    assign count_en = (state == RUN) || ((state == FINISHING) && (drain_q != '0));
    assign arm      = (state == RUN);

    assign status    = {28'b0, state, timeout_o, done_o};
    assign testnum_o = testnum_q;

    sim_ctrl_wdog u_wdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .arm      (arm),
        .limit    (wdog_q),
        .cycle    (cycle),
        .hit      (hit)
    );

    // Read multiplexer; unmapped words read as zero.
    always_comb begin
        read_data = 32'd0;
        if (sel_testnum)       read_data = testnum_q;
        else if (sel_finish)   read_data = code_q;
        else if (sel_cycle_lo) read_data = cycle[31:0];
        else if (sel_cycle_hi) read_data = cycle[63:32];
        else if (sel_wdog)     read_data = wdog_q;
        else if (sel_status)   read_data = status;
    end

    // Register one-cycle read responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rdata_o  <= 32'd0;
            bus.rvalid_o <= 1'b0;
        end else begin
            bus.rvalid_o <= rd;
            if (rd) begin
                bus.rdata_o <= read_data;
            end
        end
    end

    // Register writes and the RUN -> FINISHING -> DONE controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            testnum_q <= 32'd0;
            code_q    <= 32'd0;
            wdog_q    <= WDOG_RESET;
            drain_q   <= '0;
            verdict_q <= 1'b0;
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (wr && sel_testnum && (state != DONE)) begin
                testnum_q <= bus.wdata_i;
            end
            if (wr && sel_wdog && (state != DONE)) begin
                wdog_q <= bus.wdata_i;
            end
            case (state)
                RUN: begin
                    if (fin_wr) begin
                        code_q    <= bus.wdata_i;
                        verdict_q <= (bus.wdata_i == PASS_CODE);
                        drain_q   <= DRAIN_LOAD;
                        state     <= FINISHING;
                    end else if (hit) begin
                        code_q    <= TIMEOUT_CODE;
                        verdict_q <= 1'b0;
                        timeout_o <= 1'b1;
                        drain_q   <= DRAIN_LOAD;
                        state     <= FINISHING;
                    end
                end
                FINISHING: begin
                    if (drain_q == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        pass_o <= verdict_q;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_ctrl.sv
// Scoreboard bench for sim_ctrl: the driver applies directed and random bus
// traffic, predicts every read reply from an edge-counting reference model
// and queues it; a separate monitor pops and compares whenever rvalid shows.
module tb_sim_ctrl;
    import sim_ctrl_pkg::*;

    localparam int          AW       = 8;
    localparam int          DRAIN    = 4;
    localparam logic [31:0] WDOG_RST = 32'd100000;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  addr;
        int          due;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done, pass, timeout;
    logic [31:0] testnum;

    int vectors     = 0;
    int miscompares = 0;
    int pe_cnt      = 0;
    rd_exp_t exp_q[$];

    // Reference model: what the peripheral should hold, in terms of edges
    // since reset and the edge at which a verdict was accepted.
    longint      m_edges;
    longint      m_fin;
    logic        m_verdict;
    logic        m_timeout;
    logic [31:0] m_code;
    logic [31:0] m_testnum;
    logic [31:0] m_wdog;

    logic [7:0] addr_tab [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

    sim_ctrl_if #(.AW(AW)) bus();

    sim_ctrl #(
        .AW           (AW),
        .DRAIN_CYCLES (DRAIN),
        .WDOG_RESET   (WDOG_RST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .done_o    (done),
        .pass_o    (pass),
        .testnum_o (testnum),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pe_cnt <= pe_cnt + 1;

    // 0 = running, 1 = draining, 2 = done.
    function automatic int phase();
        if (m_fin < 0) return 0;
        if (m_edges >= m_fin + DRAIN + 1) return 2;
        return 1;
    endfunction

    function automatic logic [63:0] cyc();
        if (phase() == 2) return 64'(m_fin + DRAIN);
        return 64'(m_edges);
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] addr);
        logic [7:0]  w;
        logic [63:0] c;
        logic [1:0]  p;
        w = {addr[7:2], 2'b00};
        c = cyc();
        p = 2'(phase());
        case (w)
            SC_TESTNUM:  return m_testnum;
            SC_FINISH:   return m_code;
            SC_CYCLE_LO: return c[31:0];
            SC_CYCLE_HI: return c[63:32];
            SC_WDOG:     return m_wdog;
            SC_STATUS:   return {28'b0, p, m_timeout, (p == 2'd2)};
            default:     return 32'd0;
        endcase
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, m_edges);
        end
    endtask

    task automatic checkOutput();
        logic d;
        d = (phase() == 2);
        check1("done_o",    {31'b0, done},    {31'b0, d});
        check1("pass_o",    {31'b0, pass},    {31'b0, d & m_verdict});
        check1("timeout_o", {31'b0, timeout}, {31'b0, m_timeout});
        check1("testnum_o", testnum,          m_testnum);
    endtask

    task automatic applyStimulus(input logic req, input logic we,
                                 input logic [7:0] addr, input logic [31:0] data);
        logic [7:0]  w;
        logic [63:0] c;
        int          ph;
        logic        hit, fin;
        w  = {addr[7:2], 2'b00};
        ph = phase();
        c  = cyc();
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = data;
        if (req && !we) exp_q.push_back('{data: exp_read(addr), addr: addr, due: pe_cnt + 1});
        hit = (ph == 0) && (m_wdog != 32'd0) && (c[31:0] == m_wdog);
        fin = req && we && (ph == 0) && (w == SC_FINISH) && (data != 32'd0);
        if (req && we && ph != 2) begin
            if (w == SC_TESTNUM) m_testnum = data;
            if (w == SC_WDOG)    m_wdog    = data;
        end
        if (fin) begin
            m_fin     = m_edges + 1;
            m_verdict = (data == PASS_CODE);
            m_code    = data;
        end else if (hit) begin
            m_fin     = m_edges + 1;
            m_verdict = 1'b0;
            m_timeout = 1'b1;
            m_code    = TIMEOUT_CODE;
        end
        m_edges++;
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        checkOutput();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        applyStimulus(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 32'd0);
    endtask

    task automatic idle_until(input longint e);
        while (m_edges < e) idle(1);
    endtask

    // Assert reset mid-cycle, check outputs clear with no clock edge, release.
    task automatic doReset();
        @(negedge clk);
        #1;
        rst       = 1'b0;
        bus.req_i = 1'b0;
        #1;
        check1("reset done_o",    {31'b0, done},         32'd0);
        check1("reset pass_o",    {31'b0, pass},         32'd0);
        check1("reset timeout_o", {31'b0, timeout},      32'd0);
        check1("reset testnum_o", testnum,               32'd0);
        check1("reset rvalid_o",  {31'b0, bus.rvalid_o}, 32'd0);
        check1("reset rdata_o",   bus.rdata_o,           32'd0);
        exp_q.delete();
        m_edges   = 0;
        m_fin     = -1;
        m_verdict = 1'b0;
        m_timeout = 1'b0;
        m_code    = 32'd0;
        m_testnum = 32'd0;
        m_wdog    = WDOG_RST;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare each read reply against the queued prediction.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (exp_q.size() > 0 && exp_q[0].due == pe_cnt) begin
            e = exp_q.pop_front();
            vectors++;
            if (!bus.rvalid_o || bus.rdata_o !== e.data) begin
                miscompares++;
                $display("[TB] FAIL read %h: rvalid=%0b rdata=%h, expected rvalid=1 rdata=%h",
                         e.addr, bus.rvalid_o, bus.rdata_o, e.data);
            end
        end else if (bus.rvalid_o === 1'b1) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rvalid: got 1 with no read outstanding, expected 0");
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL time limit: got no end of stimulus, expected completion");
        $fatal(1, "[TB] time limit exceeded");
    end

    initial begin
        int          r;
        logic [7:0]  a;
        logic [31:0] d;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;

        // Pass with test number, STATUS in each state.
        doReset();
        rd(SC_STATUS);
        wr(SC_TESTNUM, 32'd5);
        idle_until(9);
        wr(SC_FINISH, 32'd1);
        rd(SC_STATUS);
        idle(3);
        repeat (4) rd(SC_STATUS);
        rd(SC_FINISH);
        rd(SC_TESTNUM);

        // Fail code, first verdict wins, writes ignored once done.
        doReset();
        wr(SC_TESTNUM, 32'd7);
        wr(SC_FINISH, 32'd3);
        wr(SC_FINISH, 32'd2);
        wr(SC_TESTNUM, 32'd8);
        idle(6);
        rd(SC_FINISH);
        wr(SC_TESTNUM, 32'd9);
        wr(SC_WDOG, 32'd5);
        wr(SC_FINISH, 32'd1);
        rd(SC_TESTNUM);
        rd(SC_WDOG);
        rd(8'h20);
        wr(8'h20, 32'h1234_5678);
        rd(8'h16);

        // Watchdog timeout.
        doReset();
        wr(SC_WDOG, 32'd50);
        idle_until(52);
        rd(SC_STATUS);
        idle_until(60);
        rd(SC_STATUS);
        rd(SC_FINISH);
        rd(SC_CYCLE_LO);
        rd(SC_CYCLE_HI);

        // FINISH write on the watchdog-hit edge: software verdict wins.
        doReset();
        wr(SC_WDOG, 32'd30);
        idle_until(30);
        wr(SC_FINISH, 32'd1);
        idle(7);
        rd(SC_STATUS);

        // WDOG rewrite on the hit edge still compares the old limit.
        doReset();
        wr(SC_WDOG, 32'd20);
        idle_until(20);
        wr(SC_WDOG, 32'd0);
        idle(7);
        rd(SC_STATUS);
        rd(SC_WDOG);

        // Asynchronous reset while draining.
        doReset();
        wr(SC_TESTNUM, 32'd3);
        wr(SC_FINISH, 32'd1);
        idle(2);
        doReset();
        rd(SC_WDOG);
        rd(SC_STATUS);
        rd(SC_FINISH);
        idle(10);

        // Random traffic.
        for (int k = 0; k < 6; k++) begin
            doReset();
            if ($urandom_range(0, 1) == 1) wr(SC_WDOG, 32'($urandom_range(15, 70)));
            for (int i = 0; i < 100; i++) begin
                r = $urandom_range(0, 19);
                a = addr_tab[$urandom_range(0, 7)] | 8'($urandom_range(0, 3));
                if (r < 8) begin
                    rd(a);
                end else if (r < 12) begin
                    wr(SC_TESTNUM | 8'($urandom_range(0, 3)), $urandom);
                end else if (r < 14) begin
                    wr(SC_WDOG, 32'($urandom_range(0, 120)));
                end else if (r == 14) begin
                    case ($urandom_range(0, 2))
                        0:       d = 32'd0;
                        1:       d = 32'd1;
                        default: d = $urandom;
                    endcase
                    wr(SC_FINISH, d);
                end else if (r == 15) begin
                    wr(a, $urandom);
                end else begin
                    idle(1);
                end
            end
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
